// File: rtl/accumulator_feeder_pkg.sv
// Shared definitions for the accumulator feeder: FSM state encoding and
// default sizing used by the top level and its input buffer.
package acc_feeder_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned BLOCK_LEN_DEF  = 1024;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned TIMEOUT_DEF    = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_FLUSH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // Width able to hold every value 0..max inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/accumulator_feeder_fifo.sv
// Synchronous input buffer for the accumulator feeder. Full/empty are
// registered, so a word pushed into an empty buffer is only poppable from
// the following cycle (no write-to-read bypass).
module accumulator_feeder_fifo
    import acc_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_count_nxt;

    assign w_push    = i_wr_en && !r_full;
    assign w_pop     = i_rd_en && !r_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

    // Next occupancy from the push/pop pair of this cycle.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); flags registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

endmodule

// File: rtl/accumulator_feeder.sv
// Streams BLOCK_LEN buffered words into an external accumulator, keeps a
// reference sum of what was sent, then captures and checks the accumulator
// total (or flags a timeout) and holds it until acknowledged.
module accumulator_feeder
    import acc_feeder_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned BLOCK_LEN  = BLOCK_LEN_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic [DATA_W-1:0] load,
    output logic              load_valid,
    input  logic [DATA_W-1:0] acc_result,
    input  logic              acc_done,
    output logic [DATA_W-1:0] sum_out,
    output logic              sum_valid,
    input  logic              sum_ack,
    output logic [DATA_W-1:0] ref_sum,
    output logic              mismatch,
    output logic              timeout,
    output logic              busy
);

    localparam int unsigned CNT_W = cnt_width(BLOCK_LEN);
    localparam int unsigned TMO_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] BLOCK_LAST = CNT_W'(BLOCK_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [DATA_W-1:0] r_load;
    logic              r_load_valid;
    logic [DATA_W-1:0] r_ref_sum;
    logic [DATA_W-1:0] r_sum_out;
    logic              r_sum_valid;
    logic              r_mismatch;
    logic              r_timeout;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic [DATA_W-1:0] w_rd_data;

    assign w_pop = (r_state == ST_STREAM) && !w_empty;

    accumulator_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (in_valid),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign in_ready   = !w_full;
    assign load       = r_load;
    assign load_valid = r_load_valid;
    assign sum_out    = r_sum_out;
    assign sum_valid  = r_sum_valid;
    assign ref_sum    = r_ref_sum;
    assign mismatch   = r_mismatch;
    assign timeout    = r_timeout;
    assign busy       = (r_state != ST_IDLE);

    // Block sequencer: streaming, flush bubble, result wait and hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_word_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_load       <= '0;
            r_load_valid <= 1'b0;
            r_ref_sum    <= '0;
            r_sum_out    <= '0;
            r_sum_valid  <= 1'b0;
            r_mismatch   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_load       <= '0;
            r_load_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_STREAM;
                        r_word_cnt <= '0;
                        r_ref_sum  <= '0;
                        r_sum_out  <= '0;
                        r_mismatch <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (w_pop) begin
                        r_load       <= w_rd_data;
                        r_load_valid <= 1'b1;
                        r_ref_sum    <= r_ref_sum + w_rd_data;
                        r_word_cnt   <= r_word_cnt + 1'b1;
                        if (r_word_cnt == BLOCK_LAST) begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state   <= ST_WAIT;
                    r_tmo_cnt <= '0;
                end
                ST_WAIT: begin
                    if (acc_done) begin
                        r_sum_out   <= acc_result;
                        r_mismatch  <= (acc_result != r_ref_sum);
                        r_timeout   <= 1'b0;
                        r_sum_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_sum_out   <= '0;
                        r_mismatch  <= 1'b1;
                        r_timeout   <= 1'b1;
                        r_sum_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (sum_ack) begin
                        r_sum_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
